// File: rtl/cnn_pkg.sv
// Shared CNN constants and the conv1 read-sequencer state type.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cnn_pkg;

  // conv1 output feature map is 12x12 per channel, two channels back to back
  localparam int CONV1_MAP_W     = 12;
  localparam int CONV1_CH_STRIDE = 144;

  // pool1 output is 6x6; one 2x2 window per output pixel
  localparam int POOL1_OUT_W     = 6;

  // conv1 output memory address width
  localparam int CONV1_ADDR_W    = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } conv1_rd_state_t;

endpackage

// File: rtl/conv1_mem_read_if.sv
// Control/address bundle between the conv1 memory reader and its neighbours.
// Latency: none (wires only).
// Backpressure: stall flows toward the reader, everything else away from it.
interface conv1_mem_read_if;
  import cnn_pkg::*;

  logic                    start;
  logic                    stall;
  logic [CONV1_ADDR_W-1:0] addr0;
  logic [CONV1_ADDR_W-1:0] addr1;
  logic                    rd_en;
  logic                    rd_valid;
  logic                    win_first;
  logic                    win_last;
  logic                    busy;
  logic                    done;

  // controller side: issues start, applies stall, observes the reader
  modport master (
    output start, stall,
    input  addr0, addr1, rd_en, rd_valid, win_first, win_last, busy, done
  );

  // reader side
  modport slave (
    input  start, stall,
    output addr0, addr1, rd_en, rd_valid, win_first, win_last, busy, done
  );

endinterface

// File: rtl/conv1_rd_addr_gen.sv
// Window counters and address arithmetic for the conv1 output scan.
// Latency: addresses are combinational from the registered counters.
// Backpressure: counters only move when adv is high, so a stall freezes them.
module conv1_rd_addr_gen
  import cnn_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    adv,
  output logic [CONV1_ADDR_W-1:0] addr0,
  output logic [CONV1_ADDR_W-1:0] addr1,
  output logic [1:0]              sub,
  output logic                    last
);

  localparam logic [2:0] WIN_MAX = 3'(POOL1_OUT_W - 1);

  logic [2:0] win_row;
  logic [2:0] win_col;
  logic [1:0] sub_q;
  logic [CONV1_ADDR_W-1:0] row_lin;
  logic [CONV1_ADDR_W-1:0] col_lin;

  // sub is the fastest digit, then win_col, then win_row; wraps after the last window
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_row <= '0;
      win_col <= '0;
      sub_q   <= '0;
    end else if (clear) begin
      win_row <= '0;
      win_col <= '0;
      sub_q   <= '0;
    end else if (adv) begin
      sub_q <= sub_q + 2'd1;
      if (sub_q == 2'd3) begin
        if (win_col == WIN_MAX) begin
          win_col <= '0;
          win_row <= (win_row == WIN_MAX) ? 3'd0 : win_row + 3'd1;
        end else begin
          win_col <= win_col + 3'd1;
        end
      end
    end
  end

  // sub[1] selects the lower row of the window, sub[0] the right column
  always_comb begin
    row_lin = {5'd0, win_row, 1'b0} + {8'd0, sub_q[1]};
    col_lin = {5'd0, win_col, 1'b0} + {8'd0, sub_q[0]};
    addr0   = CONV1_ADDR_W'(row_lin * CONV1_ADDR_W'(CONV1_MAP_W)) + col_lin;
    addr1   = addr0 + CONV1_ADDR_W'(CONV1_CH_STRIDE);
  end

  assign sub  = sub_q;
  assign last = (win_row == WIN_MAX) && (win_col == WIN_MAX) && (sub_q == 2'd3);

endmodule

// File: rtl/conv1_mem_read.sv
// Scans the two-channel conv1 output memory in 2x2 pooling-window order.
// Latency: rd_valid/win_first/win_last trail rd_en by one cycle (memory latency).
// Backpressure: stall drops rd_en and freezes addresses (only with CONV1_RD_STALL_EN).
module conv1_mem_read
  import cnn_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  conv1_mem_read_if.slave    bus
);

  conv1_rd_state_t state_q;
  conv1_rd_state_t state_d;

  logic                    stall_eff;
  logic                    rd_en;
  logic                    clear;
  logic                    last;
  logic [1:0]              sub;
  logic [1:0]              sub_d_q;
  logic                    rd_valid_q;
  logic [CONV1_ADDR_W-1:0] addr0;
  logic [CONV1_ADDR_W-1:0] addr1;

`ifdef CONV1_RD_STALL_EN
  assign stall_eff = bus.stall;
`else
  // without the stall option the pass runs at one read per cycle regardless of pool1
  assign stall_eff = 1'b0;
`endif

  conv1_rd_addr_gen u_addr_gen (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .adv   (rd_en),
    .addr0 (addr0),
    .addr1 (addr1),
    .sub   (sub),
    .last  (last)
  );

  // state register; reset mid-pass aborts straight to IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state and read strobe; start is only honoured when not mid-pass
  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    clear   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = READ;
          clear   = 1'b1;
        end
      end
      READ: begin
        if (!stall_eff) begin
          rd_en = 1'b1;
          if (last) state_d = DRAIN;
        end
      end
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // one-cycle valid pipeline matching the memory read latency, carrying the window position
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      sub_d_q    <= '0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) sub_d_q <= sub;
    end
  end

  assign bus.addr0     = addr0;
  assign bus.addr1     = addr1;
  assign bus.rd_en     = rd_en;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.win_first = rd_valid_q && (sub_d_q == 2'd0);
  assign bus.win_last  = rd_valid_q && (sub_d_q == 2'd3);
  assign bus.busy      = (state_q == READ) || (state_q == DRAIN);
  assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_conv1_mem_read.sv
// Self-checking bench for conv1_mem_read: table of pass scenarios plus random stall passes.
// Expected behaviour comes from a read-schedule model built from window order and stall pattern.
// Works for builds with and without CONV1_RD_STALL_EN.
module tb_conv1_mem_read;

`ifdef CONV1_RD_STALL_EN
  localparam bit SE = 1'b1;
`else
  localparam bit SE = 1'b0;
`endif
  localparam int MAXC = 511;
  localparam int NRD  = 144;

  logic clk = 1'b0;
  logic reset;
  conv1_mem_read_if bus();

  conv1_mem_read dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int  exp_addr [NRD];
  bit  stall_pat [MAXC+1];
  int  first4 [4] = '{0, 1, 12, 13};
  int  last4  [4] = '{130, 131, 142, 143};

  typedef struct {
    string nm;
    int    st_lo;
    int    st_hi;
    int    restart;
    int    abort_c;
    int    exp_done;
  } vec_t;

  task automatic chk(input string nm, input int c, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, c, act, exp);
    end
  endtask

  // Run one pass: start in cycle 0, optional re-pulse and optional reset abort.
  // exp_done < -1 means take the done cycle from the model.
  task automatic run_pass(input string nm, input int restart, input int abort_c, input int exp_done);
    bit is_read [MAXC+1];
    int read_idx [MAXC+1];
    int k, last, end_c, first_done, nvalid, nlast, exp_d;
    bit aborted;
    int obs [$];

    for (int c = 0; c <= MAXC; c++) begin
      is_read[c]  = 1'b0;
      read_idx[c] = 0;
    end
    k = 0;
    last = 0;
    for (int c = 1; c <= MAXC && k < NRD; c++) begin
      read_idx[c] = k;
      if (!(SE && stall_pat[c])) begin
        is_read[c] = 1'b1;
        k++;
        last = c;
      end
    end
    end_c = (abort_c >= 0) ? abort_c : last + 3;
    if (end_c > MAXC) end_c = MAXC;

    first_done = -1;
    nvalid = 0;
    nlast = 0;
    aborted = 1'b0;
    obs = {};

    for (int c = 0; c <= end_c; c++) begin
      bus.start = (c == 0) || (c == restart);
      bus.stall = stall_pat[c];
      if (c == abort_c) begin
        bus.start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk({nm, ":rst_addr0"}, c, bus.addr0, 0);
        chk({nm, ":rst_addr1"}, c, bus.addr1, 144);
        chk({nm, ":rst_rd_en"}, c, bus.rd_en, 0);
        chk({nm, ":rst_rd_valid"}, c, bus.rd_valid, 0);
        chk({nm, ":rst_win_first"}, c, bus.win_first, 0);
        chk({nm, ":rst_win_last"}, c, bus.win_last, 0);
        chk({nm, ":rst_busy"}, c, bus.busy, 0);
        chk({nm, ":rst_done"}, c, bus.done, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int j = 1; j <= 5; j++) begin
          @(negedge clk);
          chk({nm, ":post_rst_rd_valid"}, c + j, bus.rd_valid, 0);
          chk({nm, ":post_rst_done"}, c + j, bus.done, 0);
          chk({nm, ":post_rst_busy"}, c + j, bus.busy, 0);
          @(posedge clk); #1;
        end
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
      chk({nm, ":rd_en"}, c, bus.rd_en, int'(is_read[c]));
      chk({nm, ":busy"}, c, bus.busy, int'(c >= 1 && c <= last + 1));
      if (c >= 1) begin
        chk({nm, ":done"}, c, bus.done, int'(c >= last + 2));
        chk({nm, ":rd_valid"}, c, bus.rd_valid, int'(is_read[c-1]));
        chk({nm, ":win_first"}, c, bus.win_first, int'(is_read[c-1] && read_idx[c-1] % 4 == 0));
        chk({nm, ":win_last"}, c, bus.win_last, int'(is_read[c-1] && read_idx[c-1] % 4 == 3));
      end
      if (c >= 1 && c <= last) begin
        chk({nm, ":addr0"}, c, bus.addr0, exp_addr[read_idx[c]]);
        chk({nm, ":addr1"}, c, bus.addr1, exp_addr[read_idx[c]] + 144);
      end
      if (bus.rd_en === 1'b1) obs.push_back(int'(bus.addr0));
      if (bus.rd_valid === 1'b1) nvalid++;
      if (bus.win_last === 1'b1) nlast++;
      if (c >= 1 && bus.done === 1'b1 && first_done < 0) first_done = c;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;

    if (!aborted) begin
      exp_d = (exp_done < -1) ? last + 2 : exp_done;
      chk({nm, ":done_cycle"}, 0, first_done, exp_d);
      chk({nm, ":n_reads"}, 0, obs.size(), NRD);
      chk({nm, ":n_valid"}, 0, nvalid, NRD);
      chk({nm, ":n_win_last"}, 0, nlast, 36);
      if (obs.size() == NRD) begin
        for (int i = 0; i < 4; i++) begin
          chk({nm, ":first4"}, i, obs[i], first4[i]);
          chk({nm, ":last4"}, i, obs[NRD-4+i], last4[i]);
        end
      end
    end
  endtask

  vec_t vecs [7];

  initial begin
    // window order from the definition: row-major windows, 2x2 raster inside each
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        for (int s = 0; s < 4; s++)
          exp_addr[(r*6 + c)*4 + s] = (2*r + s/2)*12 + 2*c + s%2;

    vecs[0] = '{"basic",       -1,  -1,  -1, -1, 146};
    vecs[1] = '{"stall10_14",  10,  14,  -1, -1, SE ? 151 : 146};
    vecs[2] = '{"repulse20",   -1,  -1,  20, -1, 146};
    vecs[3] = '{"reset50",     -1,  -1,  -1, 50, -1};
    vecs[4] = '{"after_reset", -1,  -1,  -1, -1, 146};
    vecs[5] = '{"stall_long",   1, SE ? 50 : MAXC, -1, -1, SE ? 196 : 146};
    vecs[6] = '{"from_done",   -1,  -1,  -1, -1, 146};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset:addr0", 0, bus.addr0, 0);
    chk("reset:addr1", 0, bus.addr1, 144);
    chk("reset:rd_en", 0, bus.rd_en, 0);
    chk("reset:rd_valid", 0, bus.rd_valid, 0);
    chk("reset:win_first", 0, bus.win_first, 0);
    chk("reset:win_last", 0, bus.win_last, 0);
    chk("reset:busy", 0, bus.busy, 0);
    chk("reset:done", 0, bus.done, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) begin
      for (int c = 0; c <= MAXC; c++)
        stall_pat[c] = (c >= vecs[v].st_lo) && (c <= vecs[v].st_hi) && (vecs[v].st_lo >= 0);
      if (v == 6) chk("from_done:done_before", 0, bus.done, 1);
      run_pass(vecs[v].nm, vecs[v].restart, vecs[v].abort_c, vecs[v].exp_done);
      repeat (2) @(posedge clk);
      #1;
    end

    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c <= MAXC; c++)
        stall_pat[c] = ($urandom_range(0, 3) == 0);
      run_pass("random", (p % 2 == 0) ? int'($urandom_range(2, 100)) : -1, -1, -2);
      repeat (int'($urandom_range(0, 3))) @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
